// File: rtl/vga_timing_aot.sv
// VGA timing generator with a display-aligned coordinate pair and an
// ahead-of-time pair that leads it by LOOKAHEAD pixels in raster order.
module vga_timing_aot #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int H_SYNC_POL     = 0,
  parameter int V_SYNC_POL     = 0,
  parameter int LOOKAHEAD      = 2,
  parameter int FRAME_W        = 8,
  localparam int H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int HW            = $clog2(H_WHOLE_LINE),
  localparam int VW            = $clog2(V_WHOLE_LINE)
) (
  input  logic               vga_pix_clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  output logic [HW-1:0]      sx,
  output logic [VW-1:0]      sy,
  output logic               display_enabled,
  output logic               hsync,
  output logic               vsync,
  output logic [HW-1:0]      sx_aot,
  output logic [VW-1:0]      sy_aot,
  output logic               display_enabled_aot,
  output logic               line_stb_aot,
  output logic               frame_stb_aot,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [HW-1:0] H_LAST     = HW'(H_WHOLE_LINE - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE_AREA);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_WHOLE_LINE - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE_AREA);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic          H_ON       = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          V_ON       = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [HW-1:0] AOT_X0     = HW'(LOOKAHEAD);
  localparam logic          DE_AOT0    = (LOOKAHEAD < H_VISIBLE_AREA) ? 1'b1 : 1'b0;

  if (LOOKAHEAD < 0 || LOOKAHEAD >= H_WHOLE_LINE) begin : g_bad_lookahead
    $error("vga_timing_aot: LOOKAHEAD must lie in 0..H_WHOLE_LINE-1");
  end
  if (H_VISIBLE_AREA == 0 || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 || H_BACK_PORCH == 0 ||
      V_VISIBLE_AREA == 0 || V_FRONT_PORCH == 0 || V_SYNC_PULSE == 0 || V_BACK_PORCH == 0)
  begin : g_bad_timing
    $error("vga_timing_aot: timing parameters must be non-zero");
  end

  function automatic logic [HW-1:0] next_x(input logic [HW-1:0] x);
    return (x == H_LAST) ? '0 : x + HW'(1);
  endfunction

  function automatic logic [VW-1:0] next_y(input logic [HW-1:0] x, input logic [VW-1:0] y);
    if (x != H_LAST) return y;
    else return (y == V_LAST) ? '0 : y + VW'(1);
  endfunction

  function automatic logic h_level(input logic [HW-1:0] x);
    return (x >= H_SYNC_BEG && x < H_SYNC_END) ? H_ON : ~H_ON;
  endfunction

  function automatic logic v_level(input logic [VW-1:0] y);
    return (y >= V_SYNC_BEG && y < V_SYNC_END) ? V_ON : ~V_ON;
  endfunction

  logic [HW-1:0] sx_nxt_s;
  logic [VW-1:0] sy_nxt_s;
  logic [HW-1:0] sx_aot_nxt_s;
  logic [VW-1:0] sy_aot_nxt_s;

  assign sx_nxt_s     = next_x(sx);
  assign sy_nxt_s     = next_y(sx, sy);
  assign sx_aot_nxt_s = next_x(sx_aot);
  assign sy_aot_nxt_s = next_y(sx_aot, sy_aot);

  // Both pairs step in lockstep, so the reset offset keeps the lead forever.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      sx                  <= '0;
      sy                  <= '0;
      display_enabled     <= 1'b1;
      hsync               <= ~H_ON;
      vsync               <= ~V_ON;
      sx_aot              <= AOT_X0;
      sy_aot              <= '0;
      display_enabled_aot <= DE_AOT0;
      frame_count         <= '0;
    end else if (pix_ce) begin
      sx                  <= sx_nxt_s;
      sy                  <= sy_nxt_s;
      display_enabled     <= (sx_nxt_s < H_VIS) && (sy_nxt_s < V_VIS);
      hsync               <= h_level(sx_nxt_s);
      vsync               <= v_level(sy_nxt_s);
      sx_aot              <= sx_aot_nxt_s;
      sy_aot              <= sy_aot_nxt_s;
      display_enabled_aot <= (sx_aot_nxt_s < H_VIS) && (sy_aot_nxt_s < V_VIS);
      if (sx == H_LAST && sy == V_LAST) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

  assign line_stb_aot  = pix_ce && (sx_aot == '0);
  assign frame_stb_aot = pix_ce && (sx_aot == '0) && (sy_aot == '0);

endmodule

// File: tb/tb_vga_timing_aot.sv
// Bench for vga_timing_aot: a raster-position model checked every cycle on
// three builds (default 800x525, small 18x12 with long lead, small with no lead).
module tb_vga_timing_aot;

  localparam int S_HV = 10, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int TOT[3] = '{420000, 216, 216};

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic pix_ce = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d_sx, d_sy, d_sxa, d_sya;
  logic [4:0] s_sx, s_sxa, z_sx, z_sxa;
  logic [3:0] s_sy, s_sya, z_sy, z_sya;
  logic [7:0] d_fc;
  logic [1:0] s_fc;
  logic [2:0] z_fc;
  logic d_de, d_hs, d_vs, d_dea, d_ls, d_fs;
  logic s_de, s_hs, s_vs, s_dea, s_ls, s_fs;
  logic z_de, z_hs, z_vs, z_dea, z_ls, z_fs;

  vga_timing_aot dut_d (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .sx(d_sx), .sy(d_sy), .display_enabled(d_de), .hsync(d_hs), .vsync(d_vs),
    .sx_aot(d_sxa), .sy_aot(d_sya), .display_enabled_aot(d_dea),
    .line_stb_aot(d_ls), .frame_stb_aot(d_fs), .frame_count(d_fc));

  vga_timing_aot #(
    .H_VISIBLE_AREA(S_HV), .H_FRONT_PORCH(S_HF), .H_SYNC_PULSE(S_HS), .H_BACK_PORCH(S_HB),
    .V_VISIBLE_AREA(S_VV), .V_FRONT_PORCH(S_VF), .V_SYNC_PULSE(S_VS), .V_BACK_PORCH(S_VB),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .LOOKAHEAD(17), .FRAME_W(2)
  ) dut_s (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .sx(s_sx), .sy(s_sy), .display_enabled(s_de), .hsync(s_hs), .vsync(s_vs),
    .sx_aot(s_sxa), .sy_aot(s_sya), .display_enabled_aot(s_dea),
    .line_stb_aot(s_ls), .frame_stb_aot(s_fs), .frame_count(s_fc));

  vga_timing_aot #(
    .H_VISIBLE_AREA(S_HV), .H_FRONT_PORCH(S_HF), .H_SYNC_PULSE(S_HS), .H_BACK_PORCH(S_HB),
    .V_VISIBLE_AREA(S_VV), .V_FRONT_PORCH(S_VF), .V_SYNC_PULSE(S_VS), .V_BACK_PORCH(S_VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .LOOKAHEAD(0), .FRAME_W(3)
  ) dut_z (
    .vga_pix_clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .sx(z_sx), .sy(z_sy), .display_enabled(z_de), .hsync(z_hs), .vsync(z_vs),
    .sx_aot(z_sxa), .sy_aot(z_sya), .display_enabled_aot(z_dea),
    .line_stb_aot(z_ls), .frame_stb_aot(z_fs), .frame_count(z_fc));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int pos[3]   = '{0, 0, 0};
  int frm[3]   = '{0, 0, 0};

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from a linear raster position and completed-frame count.
  task automatic chk_inst(input string nm,
                          input int hv, hf, hs, hb, vv, vf, vs, vb, hp, vp, la, fw,
                          input int p, fr,
                          input int a_sx, a_sy, a_de, a_hs, a_vs,
                          input int a_sxa, a_sya, a_dea, a_ls, a_fs, a_fc);
    int hw, vw, x, y, q, ax, ay;
    hw = hv + hf + hs + hb;
    vw = vv + vf + vs + vb;
    x  = p % hw;
    y  = p / hw;
    q  = (p + la) % (hw * vw);
    ax = q % hw;
    ay = q / hw;
    cmp({nm, ".sx"}, a_sx, x);
    cmp({nm, ".sy"}, a_sy, y);
    cmp({nm, ".display_enabled"}, a_de, (x < hv && y < vv) ? 1 : 0);
    cmp({nm, ".hsync"}, a_hs, (x >= hv + hf && x < hv + hf + hs) ? hp : 1 - hp);
    cmp({nm, ".vsync"}, a_vs, (y >= vv + vf && y < vv + vf + vs) ? vp : 1 - vp);
    cmp({nm, ".sx_aot"}, a_sxa, ax);
    cmp({nm, ".sy_aot"}, a_sya, ay);
    cmp({nm, ".display_enabled_aot"}, a_dea, (ax < hv && ay < vv) ? 1 : 0);
    cmp({nm, ".line_stb_aot"}, a_ls, (pix_ce && ax == 0) ? 1 : 0);
    cmp({nm, ".frame_stb_aot"}, a_fs, (pix_ce && ax == 0 && ay == 0) ? 1 : 0);
    cmp({nm, ".frame_count"}, a_fc, fr % (1 << fw));
  endtask

  // Reference raster position per build.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        pos[k] <= 0;
        frm[k] <= 0;
      end
    end else if (pix_ce) begin
      for (int k = 0; k < 3; k++) begin
        pos[k] <= (pos[k] + 1) % TOT[k];
        if (pos[k] == TOT[k] - 1) frm[k] <= frm[k] + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst("d", 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 8, pos[0], frm[0],
               d_sx, d_sy, d_de, d_hs, d_vs, d_sxa, d_sya, d_dea, d_ls, d_fs, d_fc);
      chk_inst("s", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1, 1, 17, 2, pos[1], frm[1],
               s_sx, s_sy, s_de, s_hs, s_vs, s_sxa, s_sya, s_dea, s_ls, s_fs, s_fc);
      chk_inst("z", S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 0, 0, 0, 3, pos[2], frm[2],
               z_sx, z_sy, z_de, z_hs, z_vs, z_sxa, z_sya, z_dea, z_ls, z_fs, z_fc);
      cmp("z.aot_eq_x", z_sxa, z_sx);
      cmp("z.aot_eq_y", z_sya, z_sy);
    end
  end

  int hs_cnt = 0, hs_first = -1, hs_last = -1, vs_cnt = 0, de_cnt = 0;

  initial begin
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst.sx", d_sx, 0);
    cmp("rst.sy", d_sy, 0);
    cmp("rst.sx_aot", d_sxa, 2);
    cmp("rst.sy_aot", d_sya, 0);
    cmp("rst.hsync", d_hs, 1);
    cmp("rst.vsync", d_vs, 1);
    cmp("rst.frame_count", d_fc, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmp("edge1.sx", d_sx, 1);
        cmp("edge1.sx_aot", d_sxa, 3);
      end
      if (i < 216) begin
        if (s_vs) vs_cnt++;
        if (s_de) de_cnt++;
      end
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_sx);
        hs_last = int'(d_sx);
      end
      if (i == 199) begin
        cmp("s_wrap.sx", s_sx, 1);
        cmp("s_wrap.sy", s_sy, 11);
        cmp("s_wrap.sx_aot", s_sxa, 0);
        cmp("s_wrap.sy_aot", s_sya, 0);
        cmp("s_wrap.frame_stb", s_fs, 1);
        cmp("s_wrap.dea", s_dea, 1);
      end
      if (i == 216) begin
        cmp("s_frame1.fc", s_fc, 1);
        cmp("s_frame1.sx", s_sx, 0);
        cmp("s_frame1.sy", s_sy, 0);
      end
      if (i == 648) cmp("s_frame3.fc", s_fc, 3);
    end
    cmp("line.hsync_low_count", hs_cnt, 96);
    cmp("line.hsync_first", hs_first, 656);
    cmp("line.hsync_last", hs_last, 751);
    cmp("s_frame.vsync_count", vs_cnt, 36);
    cmp("s_frame.de_count", de_cnt, 60);

    repeat (65) @(negedge clk);
    cmp("s_fc_wrap.fc", s_fc, 0);
    cmp("s_fc_wrap.sx", s_sx, 0);
    cmp("s_fc_wrap.sy", s_sy, 0);

    repeat (7934) @(negedge clk);
    cmp("d798.sx", d_sx, 798);
    cmp("d798.sy", d_sy, 10);
    cmp("d798.sx_aot", d_sxa, 0);
    cmp("d798.sy_aot", d_sya, 11);
    cmp("d798.line_stb", d_ls, 1);
    cmp("d798.frame_stb", d_fs, 0);

    repeat (101) @(negedge clk);
    @(posedge clk);
    #1 pix_ce = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp("hold.sx", d_sx, 100);
      cmp("hold.sy", d_sy, 11);
      cmp("hold.sx_aot", d_sxa, 102);
      cmp("hold.line_stb", d_ls, 0);
      cmp("hold.s_line_stb", s_ls, 0);
      cmp("hold.z_frame_stb", z_fs, 0);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 pix_ce = ~pix_ce;
    end
    @(negedge clk);
    cmp("toggle.sx", d_sx, 110);
    pix_ce = 1'b1;

    repeat (190) @(negedge clk);
    cmp("pre_rst.sx", d_sx, 300);
    #2 rst_n = 1'b0;
    #1;
    cmp("async.sx", d_sx, 0);
    cmp("async.sy", d_sy, 0);
    cmp("async.sx_aot", d_sxa, 2);
    cmp("async.sy_aot", d_sya, 0);
    cmp("async.de", d_de, 1);
    cmp("async.hsync", d_hs, 1);
    cmp("async.vsync", d_vs, 1);
    cmp("async.s_sx_aot", s_sxa, 17);
    cmp("async.s_dea", s_dea, 0);
    cmp("async.s_hsync", s_hs, 0);
    cmp("async.s_fc", s_fc, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_aot.md
Name: vga_timing_aot

Overview:
- Parametrised VGA timing generator with two coordinate sets.
- Display-aligned counters (sx, sy) drive the sync outputs and display_enabled.
- Ahead-of-time counters (sx_aot, sy_aot) lead the display counters by LOOKAHEAD pixel clocks, so the drawing pipeline's output lands exactly on the displayed pixel.
- Adds configurable resolution, sync polarity, pixel clock-enable, line/frame strobes and a frame counter.
- Sits between the pixel clock domain and drawing_logic; replaces the combinational look-ahead adder plus fixed 640x480 generator.

Parameters:
- H_VISIBLE_AREA, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_VISIBLE_AREA, 480, active lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync
- LOOKAHEAD, 2, pixel clocks the aot coordinates lead the display coordinates; legal range 0..H_WHOLE_LINE-1
- FRAME_W, 8, width of frame_count

Derived values:
- H_WHOLE_LINE = sum of the four H parameters; V_WHOLE_LINE likewise.
- HW = $clog2(H_WHOLE_LINE); VW = $clog2(V_WHOLE_LINE).

Ports:
- vga_pix_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_ce  in  1  pixel advance enable; tie high when vga_pix_clk is the true pixel clock
- sx  out  HW  display x
- sy  out  VW  display y
- display_enabled  out  1  display (sx, sy) is inside the visible area
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- sx_aot  out  HW  x coordinate LOOKAHEAD pixels ahead
- sy_aot  out  VW  y coordinate LOOKAHEAD pixels ahead
- display_enabled_aot  out  1  (sx_aot, sy_aot) is inside the visible area
- line_stb_aot  out  1  sx_aot==0 and pix_ce
- frame_stb_aot  out  1  sx_aot==0 and sy_aot==0 and pix_ce
- frame_count  out  FRAME_W  completed display frames, wraps modulo 2^FRAME_W

Behaviour:
- All outputs are registered, except the two strobes, which are AND-gated with pix_ce.
- Reset (rst_n low, asynchronous):
  - sx=0, sy=0, display_enabled=1
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL
  - sx_aot=LOOKAHEAD, sy_aot=0, display_enabled_aot=(LOOKAHEAD<H_VISIBLE_AREA)
  - frame_count=0
- Reset release takes effect on the next clock edge. Reset mid-frame returns to the reset state immediately; there is no partial-frame recovery.
- Clock-enable: on each edge with pix_ce=1, both counter pairs advance by one pixel. With pix_ce=0, every register holds its value.
- Counter advance (applies to the display pair and the aot pair):
  - x wraps H_WHOLE_LINE-1 -> 0.
  - y increments only on an x wrap; y wraps V_WHOLE_LINE-1 -> 0.
  - No arithmetic ever exceeds HW/VW bits.
- Invariant: the aot pair always equals the display pair advanced LOOKAHEAD positions in raster order, including wrap across line and frame boundaries.
- LOOKAHEAD=0: the aot outputs are identical to the display outputs.
- Sync outputs (registered, same cycle as sx/sy):
  - hsync is asserted while H_VISIBLE_AREA+H_FRONT_PORCH <= sx < that value + H_SYNC_PULSE.
  - vsync is asserted while V_VISIBLE_AREA+V_FRONT_PORCH <= sy < that value + V_SYNC_PULSE, for whole lines.
- display_enabled = sx<H_VISIBLE_AREA && sy<V_VISIBLE_AREA, coincident with sx/sy. The aot version is analogous, coincident with sx_aot/sy_aot.
- frame_count increments on the edge where the display pair wraps from (H_WHOLE_LINE-1, V_WHOLE_LINE-1) to (0,0) with pix_ce=1.
- Elaboration: $error if LOOKAHEAD >= H_WHOLE_LINE or if any timing parameter is 0.

Test Plan (defaults apply unless a scenario states otherwise: 800x525 total, LOOKAHEAD=2, pix_ce=1):
- Reset, then release: sx=0, sy=0, sx_aot=2, sy_aot=0, hsync=1, vsync=1, frame_count=0; the first edge gives sx=1, sx_aot=3.
- Display at sx=798, sy=10: sx_aot=0, sy_aot=11, line_stb_aot=1, frame_stb_aot=0. Display at sx=798, sy=524: sx_aot=0, sy_aot=0, frame_stb_aot=1.
- Run one full line: hsync=0 exactly for sx 656..751 (96 clocks). Run one full frame: vsync=0 exactly for sy 490..491. display_enabled has 640x480 ones per frame.
- 420000 enabled clocks after reset: frame_count=1 and sx=sy=0. With FRAME_W=2, 4 frames: frame_count wraps to 0.
- pix_ce low for 10 clocks at sx=100: all outputs hold and both strobes stay 0. Same check with pix_ce toggling every cycle: the counters advance once per high cycle.
- LOOKAHEAD=0 build: sx_aot==sx and sy_aot==sy on every cycle. Reset asserted at sx=300, sy=200: all outputs return to reset values asynchronously (before the next clock edge).
